// File: rtl/uart_rx_ctrl.sv
// UART receive controller: line synchronizer, start detection, mid-bit sampling,
// LSB-first frame assembly and ready/read handoff with framing/overrun flags.
module uart_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD} state_t;

    state_t                 state;
    logic                   sync1, sync2, prev;
    logic                   start_edge;
    logic [CW-1:0]          period_cnt;
    logic [CW-1:0]          period_inc;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= serial_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign start_edge = prev & ~sync2;

    always_comb begin
        period_inc = (period_cnt == PERIOD_LAST) ? '0 : period_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            period_cnt    <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            // A read clears the flags unless LOAD below re-asserts data_ready.
            if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
            case (state)
                IDLE: begin
                    period_cnt <= '0;
                    bit_cnt    <= '0;
                    if (start_edge) state <= START;
                end
                START: begin
                    if (period_cnt == HALF_LAST) begin
                        period_cnt <= '0;
                        state      <= sync2 ? IDLE : DATA;
                    end else begin
                        period_cnt <= period_inc;
                    end
                end
                DATA: begin
                    if (period_cnt == PERIOD_LAST) begin
                        period_cnt <= '0;
                        shift_reg  <= {sync2, shift_reg[DATA_BITS-1:1]};
                        bit_cnt    <= bit_cnt + BW'(1);
                        if (bit_cnt == BIT_LAST) state <= STOP;
                    end else begin
                        period_cnt <= period_inc;
                    end
                end
                STOP: begin
                    if (period_cnt == PERIOD_LAST) begin
                        period_cnt    <= '0;
                        framing_error <= ~sync2;
                        state         <= sync2 ? LOAD : IDLE;
                    end else begin
                        period_cnt <= period_inc;
                    end
                end
                LOAD: begin
                    period_cnt <= '0;
                    rx_data    <= shift_reg;
                    data_ready <= 1'b1;
                    if (data_ready && !data_read) overrun_error <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frame table, hand-written corner
// sequences and randomized frames, checked every cycle against a frame-level model.
module tb_uart_rx_ctrl;

    logic       tb_clk;
    logic       rst;
    logic       serial_in;
    logic       data_read;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;

    uart_rx_ctrl #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut (
        .clk          (tb_clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .data_read    (data_read),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    // Reference state: what the reader should see after each clock edge.
    logic [7:0]  m_data;
    logic        m_ready, m_fe, m_oe;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int unsigned read_at;
        logic [7:0]  exp_data;
        logic        exp_ready;
        logic        exp_fe;
        logic        exp_oe;
    } vec_t;

    vec_t vecs[10];

    task automatic check_outputs(input string name);
        n_cmp++;
        if ({rx_data, data_ready, framing_error, overrun_error} !== {m_data, m_ready, m_fe, m_oe}) begin
            n_bad++;
            $display("FAIL %s @%0t: got data=%h rdy=%b fe=%b oe=%b, want data=%h rdy=%b fe=%b oe=%b",
                     name, $time, rx_data, data_ready, framing_error, overrun_error,
                     m_data, m_ready, m_fe, m_oe);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_ready = 1'b0;
        m_fe    = 1'b0;
        m_oe    = 1'b0;
    endtask

    // One clock: ev=1 marks the stop-bit sample edge, ev=2 the edge a good frame is loaded.
    task automatic cycle(input logic line, input bit rd, input int unsigned ev,
                         input logic [7:0] d, input logic stp, input string name);
        serial_in = line;
        data_read = rd;
        @(posedge tb_clk);
        #1;
        data_read = 1'b0;
        if (ev == 1) m_fe = ~stp;
        if (ev == 2 && stp) begin
            m_oe    = rd ? 1'b0 : (m_ready ? 1'b1 : m_oe);
            m_ready = 1'b1;
            m_data  = d;
        end else if (rd) begin
            m_ready = 1'b0;
            m_oe    = 1'b0;
        end
        check_outputs(name);
    endtask

    task automatic idle_cycles(input int unsigned n, input bit rand_read);
        for (int unsigned i = 0; i < n; i++)
            cycle(1'b1, rand_read && ($urandom_range(0, 7) == 0), 0, 8'h00, 1'b1, "idle");
    endtask

    // Full 10-bit frame, 100 clocks; low is driven from tick 1, load is visible after tick 99.
    task automatic send_frame(input logic [7:0] d, input logic stp, input int unsigned read_at);
        logic line;
        int unsigned idx;
        int unsigned ev;
        for (int unsigned i = 1; i <= 100; i++) begin
            idx  = (i - 1) / 10;
            line = (idx == 0) ? 1'b0 : (idx <= 8) ? d[idx-1] : stp;
            ev   = (i == 98) ? 1 : (i == 99) ? 2 : 0;
            cycle(line, i == read_at, ev, d, stp, "frame");
        end
        if (!stp) idle_cycles(12, 1'b0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 0,  8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 50, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 0,  8'h11, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h55, 1'b1, 20, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hAA, 1'b1, 0,  8'hAA, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 10, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 99, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h0F, 1'b1, 0,  8'h0F, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{8'hF0, 1'b1, 99, 8'hF0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{8'h96, 1'b0, 0,  8'hF0, 1'b1, 1'b1, 1'b0};

        rst       = 1'b1;
        serial_in = 1'b0;
        data_read = 1'b0;
        model_reset();

        // Reset with the line low, released while still low, then a short low is a glitch.
        cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, "reset");
        cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, "reset");
        rst = 1'b0;
        cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, "post_reset");
        idle_cycles(30, 1'b0);
        check_val("reset_ready", {31'd0, data_ready}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].read_at);
            check_val($sformatf("vec%0d_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
            check_val($sformatf("vec%0d_flags", i), {29'd0, data_ready, framing_error, overrun_error},
                      {29'd0, vecs[i].exp_ready, vecs[i].exp_fe, vecs[i].exp_oe});
            idle_cycles(3, 1'b0);
        end

        // Glitch: 3 low clocks then high, nothing may change.
        cycle(1'b1, 1'b1, 0, 8'h00, 1'b1, "pre_glitch_read");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, "glitch");
        idle_cycles(20, 1'b0);
        check_val("glitch_flags", {29'd0, data_ready, framing_error, overrun_error}, 32'd2);

        // Mid-frame reset during data bit 4, then a clean 0x81 frame.
        send_frame(8'h5A, 1'b1, 0);
        for (int unsigned i = 1; i <= 45; i++) begin
            logic line;
            line = (i <= 10) ? 1'b0 : ((8'h33 >> ((i - 11) / 10)) & 8'h01) != 0;
            cycle(line, 1'b0, 0, 8'h00, 1'b1, "pre_reset_frame");
        end
        rst = 1'b1;
        model_reset();
        cycle(1'b1, 1'b0, 0, 8'h00, 1'b1, "mid_reset");
        rst = 1'b0;
        check_val("mid_reset_outputs", {rx_data, data_ready, framing_error, overrun_error}, 32'd0);
        idle_cycles(12, 1'b0);
        send_frame(8'h81, 1'b1, 0);
        check_val("after_reset_data", {24'd0, rx_data}, 32'h81);

        // Randomized traffic: random gaps, glitches, reads, and occasional bad stop bits.
        for (int n = 0; n < 40; n++) begin
            idle_cycles($urandom_range(0, 4), 1'b1);
            if ($urandom_range(0, 5) == 0) begin
                int unsigned len;
                len = $urandom_range(1, 3);
                for (int unsigned g = 0; g < len; g++) cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, "rand_glitch");
                idle_cycles(12, 1'b1);
            end
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0,
                       ($urandom_range(0, 2) == 0) ? $urandom_range(1, 100) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
